dmem_responder: RTL

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_load_align.sv | 25 ++
 rtl/dmem_responder.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states
// and the default memory size.
package dmem_pkg;

   localparam int MEM_BYTES_DEF = 256;

   // Access size encodings carried on req_size.
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   // Number of bytes touched by an access of the given size (1, 2, 4 or 8).
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      size_bytes = 4'd1 << size;
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Extends the low bytes of a little-endian 8-byte lane to a 64-bit load result.
module dmem_load_align
   import dmem_pkg::*;
(
   input  logic [63:0] lane_data,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [63:0] result
);

   // Pick the low 1/2/4/8 bytes and sign- or zero-extend them.
   always_comb begin
      result = lane_data;
      case (size)
         SZ_B:    result = is_unsigned ? {56'd0, lane_data[7:0]}
                                       : {{56{lane_data[7]}}, lane_data[7:0]};
         SZ_H:    result = is_unsigned ? {48'd0, lane_data[15:0]}
                                       : {{48{lane_data[15]}}, lane_data[15:0]};
         SZ_W:    result = is_unsigned ? {32'd0, lane_data[31:0]}
                                       : {{32{lane_data[31]}}, lane_data[31:0]};
         default: result = lane_data;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed access latency.
// Handshakes: a request transfers on a rising edge with req_valid && req_ready;
// a response transfers on a rising edge with resp_valid && resp_ready; the
// responder holds resp_* stable until its response transfers.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int MEM_BYTES = MEM_BYTES_DEF,
   parameter int LATENCY   = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [1:0]  dbg_state
);

   localparam int AW = $clog2(MEM_BYTES);

   state_t      state;
   logic [3:0]  cnt;
   logic        we_q, uns_q;
   logic [63:0] addr_q, wdata_q;
   logic [1:0]  size_q;
   logic [63:0] rdata_q;
   logic        err_q;
   logic [7:0]  mem [MEM_BYTES];

   // With LATENCY=1 the response is formed on the accept edge itself, so the
   // access uses the live request inputs in IDLE and the latched copy after.
   logic        cur_we, cur_uns;
   logic [63:0] cur_addr, cur_wdata;
   logic [1:0]  cur_size;
   logic [3:0]  nbytes;
   logic [AW-1:0] base;
   logic [64:0] end_addr;
   logic        cur_err;
   logic [63:0] lane, load_val;
   logic        accept, enter_resp;

   // Select the access operands for the edge that enters RESP.
   always_comb begin
      cur_we    = (state == ST_IDLE) ? req_we       : we_q;
      cur_uns   = (state == ST_IDLE) ? req_unsigned : uns_q;
      cur_addr  = (state == ST_IDLE) ? req_addr     : addr_q;
      cur_wdata = (state == ST_IDLE) ? req_wdata    : wdata_q;
      cur_size  = (state == ST_IDLE) ? req_size     : size_q;
      nbytes    = size_bytes(cur_size);
      base      = cur_addr[AW-1:0];
      // 65-bit end address so a near-top address cannot wrap into range.
      end_addr  = {1'b0, cur_addr} + 65'(nbytes);
      cur_err   = (|(cur_addr & (64'(nbytes) - 64'd1))) || (end_addr > 65'(MEM_BYTES));
   end

   // Gather the 8 bytes starting at the access address (index wraps; only
   // in-range accesses ever use the result).
   always_comb begin
      lane = '0;
      for (int i = 0; i < 8; i++) begin
         lane[8*i +: 8] = mem[base + AW'(i)];
      end
   end

   dmem_load_align u_align (
      .lane_data   (lane),
      .size        (cur_size),
      .is_unsigned (cur_uns),
      .result      (load_val)
   );

   assign accept     = (state == ST_IDLE) && req_valid;
   assign enter_resp = (accept && (LATENCY == 1)) ||
                       ((state == ST_BUSY) && (cnt == 4'd0));

   // FSM, countdown and request latch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               we_q    <= req_we;
               uns_q   <= req_unsigned;
               addr_q  <= req_addr;
               wdata_q <= req_wdata;
               size_q  <= req_size;
               cnt     <= 4'(LATENCY - 1);
               state   <= (LATENCY == 1) ? ST_RESP : ST_BUSY;
            end
            ST_BUSY: begin
               if (cnt == 4'd0) state <= ST_RESP;
               else             cnt   <= cnt - 4'd1;
            end
            ST_RESP: if (resp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Response capture on the edge entering RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (cur_we || cur_err) ? 64'd0 : load_val;
         err_q   <= cur_err;
      end
   end

   // Memory array: cleared by reset, written by an error-free store.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < MEM_BYTES; i++) mem[i] <= 8'd0;
      end else if (enter_resp && cur_we && !cur_err) begin
         for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) mem[base + AW'(i)] <= cur_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready  = (state == ST_IDLE);
   assign resp_valid = (state == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign dbg_state  = state;

endmodule
